acc_core_mc: RTL and testbench

- Parametrised multi-cycle accumulator processor core. Successor to the fixed 8-bit FSM/PC/accumulator/register-file datapath.
- Generalised data width, immediate/register-address width and PC width.
- Adds carry/zero flags, conditional and register-indirect jumps, and a ready/valid instruction-fetch handshake that tolerates wait states.
- Sits between an external instruction memory and the system top.

---
 rtl/acc_core_mc.sv | 149 ++++++++++++++
 tb/tb_acc_core_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_core_mc.sv
// Multi-cycle accumulator core: FETCH -> DECODE -> EXEC, with carry/zero flags,
// conditional and register-indirect jumps, and a wait-state tolerant fetch.
module acc_core_mc #(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 4,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [IMM_W+3:0]  imem_data,
    output logic [DATA_W-1:0] acc_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted,
    output logic [1:0]        state_out
);

    // Fetch handshake: while imem_req is high, the instruction at imem_addr is
    // accepted on the first rising edge where imem_valid is also high; the
    // address holds steady for as long as valid stays low.

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_JR  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int NREG = 1 << IMM_W;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  opr;
    logic               z;
    logic               c;
    logic [IMM_W+3:0]   instr;
    logic [DATA_W-1:0]  regs [NREG];

    logic [3:0]         op;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  res;
    logic               res_c;
    logic               upd_z;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    nxt_pc;

    assign op     = instr[IMM_W+3:IMM_W];
    assign imm    = instr[IMM_W-1:0];
    assign sum    = {1'b0, acc} + {1'b0, opr};
    assign diff   = {1'b0, acc} - {1'b0, opr};
    assign pc_inc = pc + PC_W'(1);

    always_comb begin
        res    = acc;
        res_c  = c;
        upd_z  = 1'b0;
        nxt_pc = pc_inc;
        case (op)
            OP_NOP: ;
            OP_LDI: begin res = DATA_W'(imm); upd_z = 1'b1; end
            OP_LDR: begin res = opr; upd_z = 1'b1; end
            OP_STR: ;
            OP_ADD: begin res = sum[DATA_W-1:0]; res_c = sum[DATA_W]; upd_z = 1'b1; end
            // The extra top bit of the difference is the borrow, i.e. acc < R.
            OP_SUB: begin res = diff[DATA_W-1:0]; res_c = diff[DATA_W]; upd_z = 1'b1; end
            OP_AND: begin res = acc & opr; upd_z = 1'b1; end
            OP_OR:  begin res = acc | opr; upd_z = 1'b1; end
            OP_XOR: begin res = acc ^ opr; upd_z = 1'b1; end
            OP_SHL: begin res = {acc[DATA_W-2:0], 1'b0}; res_c = acc[DATA_W-1]; upd_z = 1'b1; end
            OP_SHR: begin res = {1'b0, acc[DATA_W-1:1]}; res_c = acc[0]; upd_z = 1'b1; end
            OP_JMP: nxt_pc = PC_W'(imm);
            OP_JZ:  if (z) nxt_pc = PC_W'(imm);
            OP_JC:  if (c) nxt_pc = PC_W'(imm);
            OP_JR:  nxt_pc = PC_W'(opr);
            OP_HLT: nxt_pc = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
            acc   <= '0;
            opr   <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            instr <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        instr <= imem_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opr   <= regs[imm];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    acc <= res;
                    c   <= res_c;
                    if (upd_z) z <= (res == '0);
                    if (op == OP_STR) regs[imm] <= acc;
                    pc    <= nxt_pc;
                    state <= (op == OP_HLT) ? S_HALT : S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign acc_out   = acc;
    assign pc_out    = pc;
    assign flag_z    = z;
    assign flag_c    = c;
    assign halted    = (state == S_HALT);
    assign state_out = state;

endmodule

// File: tb/tb_acc_core_mc.sv
// Bench for acc_core_mc: directed programs plus a random program, all checked
// against an instruction-level model of the ISA.
module tb_acc_core_mc;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic [7:0] acc_out;
    logic [7:0] pc_out;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
    logic [1:0] state_out;

    logic [7:0] mem [256];
    logic       stall;

    int tests = 0;
    int fails = 0;

    int m_pc, m_acc, m_z, m_c, m_halt;
    int m_r [16];

    acc_core_mc #(.DATA_W(8), .IMM_W(4), .PC_W(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .acc_out(acc_out), .pc_out(pc_out),
        .flag_z(flag_z), .flag_c(flag_c),
        .halted(halted), .state_out(state_out)
    );

    // Zero-latency instruction memory; stall inserts wait states.
    assign imem_valid = imem_req & ~stall;
    assign imem_data  = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_pc"},    32'(pc_out),    32'(m_pc));
        check({tag, "_acc"},   32'(acc_out),   32'(m_acc));
        check({tag, "_z"},     32'(flag_z),    32'(m_z));
        check({tag, "_c"},     32'(flag_c),    32'(m_c));
        check({tag, "_state"}, 32'(state_out), m_halt ? 32'd3 : 32'd0);
        check({tag, "_halt"},  32'(halted),    32'(m_halt));
    endtask

    // Pulse rst for one edge starting from a negedge; ends on a negedge.
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_arch("reset");
        check("reset_req",  32'(imem_req),  32'd1);
        check("reset_addr", 32'(imem_addr), 32'd0);
    endtask

    // ISA-level meaning of one instruction.
    task automatic model_exec(input logic [7:0] ins);
        int op, imm, r, s, npc;
        op  = int'(ins[7:4]);
        imm = int'(ins[3:0]);
        r   = m_r[imm];
        npc = (m_pc + 1) % 256;
        case (op)
            0:  ;
            1:  m_acc = imm;
            2:  m_acc = r;
            3:  m_r[imm] = m_acc;
            4:  begin s = m_acc + r; m_c = (s > 255) ? 1 : 0; m_acc = s % 256; end
            5:  begin m_c = (m_acc < r) ? 1 : 0; m_acc = (m_acc - r + 256) % 256; end
            6:  m_acc = m_acc & r;
            7:  m_acc = m_acc | r;
            8:  m_acc = m_acc ^ r;
            9:  begin m_c = (m_acc >= 128) ? 1 : 0; m_acc = (m_acc * 2) % 256; end
            10: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
            11: npc = imm;
            12: if (m_z != 0) npc = imm;
            13: if (m_c != 0) npc = imm;
            14: npc = r;
            default: begin npc = m_pc; m_halt = 1; end
        endcase
        if (op == 1 || op == 2 || (op >= 4 && op <= 10)) m_z = (m_acc == 0) ? 1 : 0;
        m_pc = npc;
    endtask

    // Execute one instruction with k wait states; starts and ends on a negedge.
    task automatic step(input int k, input string tag);
        stall = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_wait_state"}, 32'(state_out), 32'd0);
            check({tag, "_wait_req"},   32'(imem_req),  32'd1);
            check({tag, "_wait_addr"},  32'(imem_addr), 32'(m_pc));
            check({tag, "_wait_acc"},   32'(acc_out),   32'(m_acc));
        end
        stall = 1'b0;
        model_exec(mem[m_pc[7:0]]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_arch(tag);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        clear_mem();
        @(negedge clk);

        // Program A: LDI 5; STR 3; LDI 10; ADD 3; LDR 3
        mem[0] = 8'h15; mem[1] = 8'h33; mem[2] = 8'h1A; mem[3] = 8'h43; mem[4] = 8'h23;
        do_reset();
        for (int i = 0; i < 4; i++) step(0, "progA");
        check("progA_acc15", 32'(acc_out), 32'd15);
        check("progA_pc4",   32'(pc_out),  32'd4);
        step(0, "progA_ldr");
        check("progA_r3", 32'(acc_out), 32'd5);

        // Program B: shifts, JC/JZ, SUB borrow, then a stalled fetch
        clear_mem();
        mem[0] = 8'h1F;
        for (int i = 1; i <= 5; i++) mem[i] = 8'h90;
        mem[6]  = 8'hD9; mem[9]  = 8'hC2; mem[10] = 8'h17; mem[11] = 8'h31;
        mem[12] = 8'h51; mem[13] = 8'hCF; mem[15] = 8'h12; mem[16] = 8'h51;
        mem[17] = 8'h14;
        do_reset();
        for (int i = 0; i < 5; i++) step(0, "progB_shl");
        check("shl4_acc", 32'(acc_out), 32'hF0);
        check("shl4_c",   32'(flag_c),  32'd0);
        step(0, "progB_shl5");
        check("shl5_acc", 32'(acc_out), 32'hE0);
        check("shl5_c",   32'(flag_c),  32'd1);
        step(0, "progB_jc");
        check("jc_pc", 32'(pc_out), 32'd9);
        step(0, "progB_jz");
        check("jz_nt_pc", 32'(pc_out), 32'd10);
        for (int i = 0; i < 3; i++) step(0, "progB_sub0");
        check("sub0_acc", 32'(acc_out), 32'd0);
        check("sub0_z",   32'(flag_z),  32'd1);
        check("sub0_c",   32'(flag_c),  32'd0);
        step(0, "progB_jz_t");
        check("jz_t_pc", 32'(pc_out), 32'd15);
        step(0, "progB_ldi2");
        step(0, "progB_sub");
        check("subb_acc", 32'(acc_out), 32'hFB);
        check("subb_c",   32'(flag_c),  32'd1);
        check("subb_z",   32'(flag_z),  32'd0);
        step(5, "progB_stall");
        check("stall_acc", 32'(acc_out), 32'd4);

        // Program C: build 0xFF in R2, JR 2, NOP at 0xFF wraps pc to 0
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'h34; mem[2] = 8'h10; mem[3] = 8'h54;
        mem[4] = 8'h32; mem[5] = 8'hE2;
        do_reset();
        for (int i = 0; i < 6; i++) step(0, "progC");
        check("jr_pc", 32'(pc_out), 32'hFF);
        step(0, "progC_wrap");
        check("wrap_pc", 32'(pc_out), 32'd0);

        // Program D: HLT freezes the core
        clear_mem();
        mem[0] = 8'h13; mem[1] = 8'hF0;
        do_reset();
        step(0, "progD");
        step(0, "progD_hlt");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("halt_flag", 32'(halted),   32'd1);
            check("halt_req",  32'(imem_req), 32'd0);
            check("halt_pc",   32'(pc_out),   32'd1);
            check("halt_acc",  32'(acc_out),  32'd3);
        end

        // Program E: reset during DECODE of ADD; registers come back cleared
        clear_mem();
        mem[0] = 8'h19; mem[1] = 8'h30; mem[2] = 8'h40;
        do_reset();
        step(0, "progE");
        step(0, "progE");
        @(posedge clk);
        @(negedge clk);
        check("decode_state", 32'(state_out), 32'd1);
        check("decode_req",   32'(imem_req),  32'd0);
        mem[0] = 8'h11; mem[1] = 8'h20;
        do_reset();
        step(0, "progE_ldi");
        step(0, "progE_ldr");
        check("rst_r0_cleared", 32'(acc_out), 32'd0);

        // Random program without HLT, random wait states
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom_range(0, 255));
            if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'h0;
        end
        do_reset();
        for (int i = 0; i < 300; i++) step($urandom_range(0, 2), "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
